// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage.
//   wb_state_e : load-wait FSM states.
//   F3_*       : load funct3 encodings used by the alignment logic.
package wb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB pipeline register bundle.
//   rd_data : ALU result headed for the register file
//   rd_addr : destination register index
//   dm_out  : full data-memory read word
//   reg_wr  : instruction writes a register
//   dm2reg  : write-back source is load data rather than rd_data
// MEM2WB is the producing side, WB2MEM the consuming side.
interface inf_MEM_WB #(
  parameter int DATA_BITS = 32,
  parameter int REG_BITS  = 5
);
  logic [DATA_BITS-1:0] rd_data;
  logic [REG_BITS-1:0]  rd_addr;
  logic [DATA_BITS-1:0] dm_out;
  logic                 reg_wr;
  logic                 dm2reg;

  modport MEM2WB (output rd_data, rd_addr, dm_out, reg_wr, dm2reg);
  modport WB2MEM (input  rd_data, rd_addr, dm_out, reg_wr, dm2reg);
endinterface

// File: rtl/wb_stage_ld_align.sv
// Load data alignment: selects the byte/halfword addressed by the load
// offset out of the full memory word and sign- or zero-extends it.
//   dm_out_i : full memory word
//   ld_f3_i  : load funct3
//   ld_off_i : byte offset of the load address
//   data_o   : aligned, extended result
module ld_align
  import wb_pkg::*;
#(
  parameter int DATA_BITS = 32
) (
  input  logic [DATA_BITS-1:0] dm_out_i,
  input  logic [2:0]           ld_f3_i,
  input  logic [1:0]           ld_off_i,
  output logic [DATA_BITS-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = dm_out_i[{ld_off_i, 3'b000} +: 8];
  // off[0] is deliberately ignored: misaligned halfwords read the enclosing half.
  assign half_sel = dm_out_i[{ld_off_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o = dm_out_i;
    case (ld_f3_i)
      F3_LB:   data_o = {{(DATA_BITS-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data_o = {{(DATA_BITS-16){half_sel[15]}}, half_sel};
      F3_LBU:  data_o = {{(DATA_BITS-8){1'b0}}, byte_sel};
      F3_LHU:  data_o = {{(DATA_BITS-16){1'b0}}, half_sel};
      default: data_o = dm_out_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage.
//   clk, rstn        : clock, asynchronous active-low reset
//   mem_wb           : MEM/WB payload (consuming modport)
//   mem_valid        : payload is a live instruction
//   ld_f3, ld_off    : load funct3 and byte offset
//   dm_rvalid        : dm_out carries load data this cycle
//   flush            : drop a pending load
//   rf_*             : register-file write port
//   fwd_*            : EX forwarding copy of rf_*
//   last_*           : rf_* delayed by one cycle for the ID bypass
//   wb_stall         : holds IF..MEM while load data is outstanding
//   instret          : retired-instruction counter
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int REG_BITS  = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  inf_MEM_WB.WB2MEM            mem_wb,
  input  logic                 mem_valid,
  input  logic [2:0]           ld_f3,
  input  logic [1:0]           ld_off,
  input  logic                 dm_rvalid,
  input  logic                 flush,
  output logic                 rf_we,
  output logic [REG_BITS-1:0]  rf_waddr,
  output logic [DATA_BITS-1:0] rf_wdata,
  output logic                 fwd_valid,
  output logic [REG_BITS-1:0]  fwd_addr,
  output logic [DATA_BITS-1:0] fwd_data,
  output logic                 last_we,
  output logic [REG_BITS-1:0]  last_waddr,
  output logic [DATA_BITS-1:0] last_wdata,
  output logic                 wb_stall,
  output logic [63:0]          instret
);

  wb_state_e            state_q, state_d;
  logic [REG_BITS-1:0]  h_addr_q;
  logic                 h_we_q;
  logic [2:0]           h_f3_q;
  logic [1:0]           h_off_q;
  logic                 hold_ld;

  logic                 last_we_q;
  logic [REG_BITS-1:0]  last_waddr_q;
  logic [DATA_BITS-1:0] last_wdata_q;
  logic [63:0]          instret_q;

  logic                 wr;
  logic                 retire;
  logic [2:0]           al_f3;
  logic [1:0]           al_off;
  logic [DATA_BITS-1:0] al_data;

  // In WAIT the payload on the interface belongs to a younger instruction,
  // so alignment must use the fields captured when the load arrived.
  assign al_f3  = (state_q == WAIT) ? h_f3_q  : ld_f3;
  assign al_off = (state_q == WAIT) ? h_off_q : ld_off;

  ld_align #(.DATA_BITS(DATA_BITS)) u_ld_align (
    .dm_out_i (mem_wb.dm_out),
    .ld_f3_i  (al_f3),
    .ld_off_i (al_off),
    .data_o   (al_data)
  );

  always_comb begin
    state_d  = state_q;
    wr       = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    retire   = 1'b0;
    wb_stall = 1'b0;
    hold_ld  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          if (!mem_wb.dm2reg) begin
            wr       = mem_wb.reg_wr;
            rf_waddr = mem_wb.rd_addr;
            rf_wdata = mem_wb.rd_data;
            retire   = 1'b1;
          end else if (dm_rvalid) begin
            wr       = mem_wb.reg_wr;
            rf_waddr = mem_wb.rd_addr;
            rf_wdata = al_data;
            retire   = 1'b1;
          end else begin
            wb_stall = 1'b1;
            hold_ld  = 1'b1;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        wb_stall = !dm_rvalid;
        // flush wins over a same-cycle response: the load is abandoned.
        if (flush) begin
          state_d = IDLE;
        end else if (dm_rvalid) begin
          wr       = h_we_q;
          rf_waddr = h_addr_q;
          rf_wdata = al_data;
          retire   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // x0 is hardwired to zero: never write it, but the instruction still retires.
  assign rf_we     = wr && (rf_waddr != '0);
  assign fwd_valid = rf_we;
  assign fwd_addr  = rf_waddr;
  assign fwd_data  = rf_wdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      h_addr_q     <= '0;
      h_we_q       <= 1'b0;
      h_f3_q       <= '0;
      h_off_q      <= '0;
      last_we_q    <= 1'b0;
      last_waddr_q <= '0;
      last_wdata_q <= '0;
      instret_q    <= '0;
    end else begin
      state_q <= state_d;
      if (hold_ld) begin
        h_addr_q <= mem_wb.rd_addr;
        h_we_q   <= mem_wb.reg_wr;
        h_f3_q   <= ld_f3;
        h_off_q  <= ld_off;
      end
      last_we_q    <= rf_we;
      last_waddr_q <= rf_waddr;
      last_wdata_q <= rf_wdata;
      instret_q    <= instret_q + 64'(retire);
    end
  end

  assign last_we    = last_we_q;
  assign last_waddr = last_waddr_q;
  assign last_wdata = last_wdata_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_valid, dm_rvalid, flush;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_off;
  logic        rf_we, fwd_valid, last_we, wb_stall;
  logic [4:0]  rf_waddr, fwd_addr, last_waddr;
  logic [31:0] rf_wdata, fwd_data, last_wdata;
  logic [63:0] instret;

  inf_MEM_WB #(.DATA_BITS(32), .REG_BITS(5)) mw ();

  wb_stage #(.DATA_BITS(32), .REG_BITS(5)) dut (
    .clk(clk), .rstn(rstn), .mem_wb(mw.WB2MEM),
    .mem_valid(mem_valid), .ld_f3(ld_f3), .ld_off(ld_off),
    .dm_rvalid(dm_rvalid), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .last_we(last_we), .last_waddr(last_waddr), .last_wdata(last_wdata),
    .wb_stall(wb_stall), .instret(instret)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a pending-load record plus counters.
  bit          m_pend;
  logic [4:0]  m_addr;
  bit          m_we;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  longint unsigned m_inst;
  bit          m_lwe;
  logic [4:0]  m_lwa;
  logic [31:0] m_lwd;

  // Values observed at the most recent mid-cycle sample.
  logic        o_we, o_stall;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_align(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // One clock: drive at posedge+1, check combinational outputs at the
  // falling edge, advance the model at the rising edge, check registers.
  task automatic step(input bit mv, input bit d2r, input bit rw, input logic [4:0] ra,
                      input logic [31:0] rdd, input logic [31:0] dmo, input logic [2:0] f3,
                      input logic [1:0] off, input bit rv, input bit fl);
    bit          e_w, e_ret, e_st, e_we, n_pend;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    mem_valid = mv; mw.dm2reg = d2r; mw.reg_wr = rw; mw.rd_addr = ra;
    mw.rd_data = rdd; mw.dm_out = dmo; ld_f3 = f3; ld_off = off;
    dm_rvalid = rv; flush = fl;
    e_w = 0; e_ret = 0; e_st = 0; e_a = '0; e_d = '0; n_pend = m_pend;
    if (!m_pend) begin
      if (mv && !d2r) begin
        e_w = rw; e_a = ra; e_d = rdd; e_ret = 1;
      end else if (mv && rv) begin
        e_w = rw; e_a = ra; e_d = ref_align(dmo, f3, off); e_ret = 1;
      end else if (mv) begin
        e_st = 1; n_pend = 1;
      end
    end else begin
      e_st = !rv;
      if (fl) n_pend = 0;
      else if (rv) begin
        e_w = m_we; e_a = m_addr; e_d = ref_align(dmo, m_f3, m_off); e_ret = 1; n_pend = 0;
      end
    end
    e_we = e_w && (e_a != 0);
    #4;
    o_we = rf_we; o_stall = wb_stall; o_waddr = rf_waddr; o_wdata = rf_wdata;
    chk("rf_we", rf_we, e_we);
    chk("fwd_valid", fwd_valid, e_we);
    chk("wb_stall", wb_stall, e_st);
    if (e_we || (!m_pend && !mv)) begin
      chk("rf_waddr", rf_waddr, e_a);
      chk("rf_wdata", rf_wdata, e_d);
      chk("fwd_addr", fwd_addr, e_a);
      chk("fwd_data", fwd_data, e_d);
    end
    @(posedge clk);
    if (!m_pend && n_pend) begin
      m_addr = ra; m_we = rw; m_f3 = f3; m_off = off;
    end
    m_pend = n_pend;
    m_inst = m_inst + 64'(e_ret);
    m_lwe = e_we; m_lwa = e_a; m_lwd = e_d;
    #1;
    chk("last_we", last_we, m_lwe);
    if (m_lwe) begin
      chk("last_waddr", last_waddr, m_lwa);
      chk("last_wdata", last_wdata, m_lwd);
    end
    chk("instret", instret, m_inst);
  endtask

  initial begin
    longint unsigned base;
    int stall_cnt;
    rstn = 1'b0;
    mem_valid = 0; dm_rvalid = 0; flush = 0; ld_f3 = '0; ld_off = '0;
    mw.rd_data = '0; mw.rd_addr = '0; mw.dm_out = '0; mw.reg_wr = 0; mw.dm2reg = 0;
    m_pend = 0; m_inst = 0; m_lwe = 0; m_addr = '0; m_we = 0; m_f3 = '0; m_off = '0;
    m_lwa = '0; m_lwd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instret", instret, 64'd0);
    chk("rst_last_we", last_we, 64'd0);
    chk("rst_last_waddr", last_waddr, 64'd0);
    chk("rst_last_wdata", last_wdata, 64'd0);
    chk("rst_stall", wb_stall, 64'd0);
    chk("rst_rf_we", rf_we, 64'd0);
    rstn = 1'b1;

    // ALU write
    step(1, 0, 1, 5'd5, 32'hDEADBEEF, 32'h0, 3'b010, 2'd0, 0, 0);
    chk("alu_we", o_we, 64'd1);
    chk("alu_waddr", o_waddr, 64'd5);
    chk("alu_wdata", o_wdata, 64'hDEADBEEF);
    chk("alu_last_wdata", last_wdata, 64'hDEADBEEF);
    chk("alu_instret", instret, 64'd1);

    // Alignment with same-cycle data
    step(1, 1, 1, 5'd9, 32'h0, 32'h80FF7F01, 3'b000, 2'd3, 1, 0);
    chk("lb_off3", o_wdata, 64'hFFFFFF80);
    step(1, 1, 1, 5'd9, 32'h0, 32'h80FF7F01, 3'b100, 2'd1, 1, 0);
    chk("lbu_off1", o_wdata, 64'h0000007F);
    step(1, 1, 1, 5'd9, 32'h0, 32'h80FF7F01, 3'b001, 2'd2, 1, 0);
    chk("lh_off2", o_wdata, 64'hFFFF80FF);
    step(1, 1, 1, 5'd9, 32'h0, 32'h80FF7F01, 3'b101, 2'd0, 1, 0);
    chk("lhu_off0", o_wdata, 64'h00007F01);
    step(1, 1, 1, 5'd9, 32'h0, 32'h80FF7F01, 3'b010, 2'd0, 1, 0);
    chk("lw", o_wdata, 64'h80FF7F01);
    step(1, 1, 1, 5'd9, 32'h0, 32'h80FF7F01, 3'b001, 2'd3, 1, 0);
    chk("lh_off3_ignores_bit0", o_wdata, 64'hFFFF80FF);

    // Delayed load to x7: 3 stalled cycles, then data arrives
    base = m_inst;
    stall_cnt = 0;
    step(1, 1, 1, 5'd7, 32'h0, 32'h0, 3'b010, 2'd0, 0, 0);
    stall_cnt += int'(o_stall);
    step(1, 0, 1, 5'd3, 32'h11111111, 32'h0, 3'b000, 2'd1, 0, 0);
    stall_cnt += int'(o_stall);
    step(1, 0, 1, 5'd4, 32'h22222222, 32'h0, 3'b000, 2'd2, 0, 0);
    stall_cnt += int'(o_stall);
    chk("dly_stall_cycles", stall_cnt, 64'd3);
    chk("dly_no_retire", instret, base);
    step(1, 0, 1, 5'd3, 32'h33333333, 32'hCAFEF00D, 3'b000, 2'd0, 1, 0);
    chk("dly_we", o_we, 64'd1);
    chk("dly_waddr", o_waddr, 64'd7);
    chk("dly_wdata", o_wdata, 64'hCAFEF00D);
    chk("dly_stall_drop", o_stall, 64'd0);
    chk("dly_retire_once", instret, base + 1);

    // Flush in WAIT with a same-cycle response
    step(1, 1, 1, 5'd12, 32'h0, 32'h0, 3'b010, 2'd0, 0, 0);
    base = m_inst;
    step(0, 0, 0, 5'd0, 32'h0, 32'h12345678, 3'b010, 2'd0, 1, 1);
    chk("flush_no_we", o_we, 64'd0);
    chk("flush_instret", instret, base);
    step(1, 0, 1, 5'd6, 32'hA5A5A5A5, 32'h0, 3'b010, 2'd0, 0, 0);
    chk("flush_idle_next", o_we, 64'd1);

    // x0 target
    base = m_inst;
    step(1, 0, 1, 5'd0, 32'hFFFFFFFF, 32'h0, 3'b010, 2'd0, 0, 0);
    chk("x0_we", o_we, 64'd0);
    chk("x0_retire", instret, base + 1);

    // Reset asserted mid-WAIT
    step(1, 1, 1, 5'd8, 32'h0, 32'h0, 3'b010, 2'd0, 0, 0);
    mem_valid = 0; dm_rvalid = 0; flush = 0;
    #2 rstn = 1'b0;
    #1;
    chk("rstw_instret", instret, 64'd0);
    chk("rstw_last_we", last_we, 64'd0);
    chk("rstw_stall", wb_stall, 64'd0);
    m_pend = 0; m_inst = 0; m_lwe = 0;
    @(posedge clk);
    #1 rstn = 1'b1;
    step(0, 0, 0, 5'd0, 32'h0, 32'h55555555, 3'b010, 2'd0, 1, 0);
    chk("rstw_no_write", o_we, 64'd0);
    chk("rstw_no_retire", instret, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 5) != 0),
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
           $urandom, $urandom, 3'($urandom), 2'($urandom),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
